// File: rtl/root_unit_if.sv
// Handshake bundle for root_unit: operation request (start/mode/num) and
// result/status (busy/done/root/rem).
interface root_unit_if #(
  parameter int WIDTH = 32
);
  localparam int RW = (WIDTH + 1) / 2;

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] num;
  logic             busy;
  logic             done;
  logic [RW-1:0]    root;
  logic [WIDTH-1:0] rem;

  modport master (
    output start, mode, num,
    input  busy, done, root, rem
  );

  modport slave (
    input  start, mode, num,
    output busy, done, root, rem
  );
endinterface

// File: rtl/root_unit.sv
// Sequential floor square/cube root with remainder, one result bit per clock
// (restoring trial method), shared between both root kinds via the mode input.
module root_unit #(
  parameter int WIDTH = 32,
  parameter int RW    = (WIDTH + 1) / 2
) (
  input  logic       clk,
  input  logic       rst,
  root_unit_if.slave bus
);
  localparam int NSQ = (WIDTH + 1) / 2;
  localparam int NCU = (WIDTH + 2) / 3;
  localparam int PW  = 3 * RW;
  localparam int IW  = (RW > 1) ? $clog2(RW) : 1;

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] num_reg, num_next;
  logic             mode_reg, mode_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [RW-1:0]    part_reg, part_next;
  logic [PW-1:0]    pow_reg, pow_next;
  logic [RW-1:0]    root_reg, root_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             done_reg, done_next;

  logic [RW-1:0] trial;
  logic [PW-1:0] trial_ext;
  logic [PW-1:0] trial_sq;
  logic [PW-1:0] trial_cu;
  logic [PW-1:0] power;
  logic [PW-1:0] num_ext;
  logic [PW-1:0] final_pow;
  logic          keep;

  // Trial power is formed at 3*RW bits so even the cube of the widest trial fits.
  always_comb begin
    trial     = part_reg | (RW'(1) << idx_reg);
    trial_ext = PW'(trial);
    trial_sq  = trial_ext * trial_ext;
    trial_cu  = trial_sq * trial_ext;
    power     = mode_reg ? trial_cu : trial_sq;
    num_ext   = PW'(num_reg);
    keep      = (power <= num_ext);
    // pow_reg tracks partial^k, so the final power needs no extra multiplier.
    final_pow = keep ? power : pow_reg;
  end

  always_comb begin
    state_next = state_reg;
    num_next   = num_reg;
    mode_next  = mode_reg;
    idx_next   = idx_reg;
    part_next  = part_reg;
    pow_next   = pow_reg;
    root_next  = root_reg;
    rem_next   = rem_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          num_next   = bus.num;
          mode_next  = bus.mode;
          part_next  = '0;
          pow_next   = '0;
          idx_next   = bus.mode ? IW'(NCU - 1) : IW'(NSQ - 1);
          state_next = CALC;
        end
      end
      CALC: begin
        part_next = keep ? trial : part_reg;
        pow_next  = final_pow;
        if (idx_reg == '0) begin
          root_next  = keep ? trial : part_reg;
          rem_next   = WIDTH'(num_ext - final_pow);
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          idx_next = idx_reg - IW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      num_reg   <= '0;
      mode_reg  <= 1'b0;
      idx_reg   <= '0;
      part_reg  <= '0;
      pow_reg   <= '0;
      root_reg  <= '0;
      rem_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      num_reg   <= num_next;
      mode_reg  <= mode_next;
      idx_reg   <= idx_next;
      part_reg  <= part_next;
      pow_reg   <= pow_next;
      root_reg  <= root_next;
      rem_reg   <= rem_next;
      done_reg  <= done_next;
    end
  end

  assign bus.busy = (state_reg == CALC);
  assign bus.done = done_reg;
  assign bus.root = root_reg;
  assign bus.rem  = rem_reg;
endmodule

// File: tb/tb_root_unit.sv
// Directed-vector and model-checked bench for root_unit at WIDTH=32 and WIDTH=8.
module tb_root_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  root_unit_if #(.WIDTH(32)) b32();
  root_unit_if #(.WIDTH(8))  b8();

  root_unit #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32));
  root_unit #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          mode;
    logic [31:0] num;
    logic [15:0] root;
    logic [31:0] rem;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Independent reference: binary search for the largest r with r^k <= n.
  function automatic longint unsigned iroot(input longint unsigned n, input bit cube, input int rw);
    longint unsigned lo, hi, mid, p;
    lo = 0;
    hi = (64'd1 << rw) - 1;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      p   = cube ? mid * mid * mid : mid * mid;
      if (p <= n) lo = mid;
      else        hi = mid - 1;
    end
    return lo;
  endfunction

  task automatic launch32(input bit m, input logic [31:0] n);
    b32.start = 1'b1;
    b32.mode  = m;
    b32.num   = n;
    @(posedge clk); #1;
    b32.start = 1'b0;
  endtask

  task automatic wait32(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!b32.done && lat < 200) begin
      if (b32.busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op32(input bit m, input logic [31:0] n, input logic [15:0] er, input logic [31:0] erem);
    int lat, bc, nexp;
    nexp = m ? 11 : 16;
    @(negedge clk);
    launch32(m, n);
    wait32(lat, bc);
    check("w32_latency", lat, nexp);
    check("w32_busy_cycles", bc, nexp);
    check("w32_root", b32.root, er);
    check("w32_rem", b32.rem, erem);
    $display("txn w32 mode=%0d num=%0d root=%0d rem=%0d lat=%0d", m, n, b32.root, b32.rem, lat);
  endtask

  task automatic op8(input bit m, input logic [7:0] n);
    int lat, bc, nexp;
    longint unsigned r, p;
    nexp = m ? 3 : 4;
    r = iroot(64'(n), m, 4);
    p = m ? r * r * r : r * r;
    @(negedge clk);
    b8.start = 1'b1;
    b8.mode  = m;
    b8.num   = n;
    @(posedge clk); #1;
    b8.start = 1'b0;
    lat = 0;
    bc  = 0;
    while (!b8.done && lat < 200) begin
      if (b8.busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
    check("w8_latency", lat, nexp);
    check("w8_busy_cycles", bc, nexp);
    check("w8_root", b8.root, r);
    check("w8_rem", b8.rem, 64'(n) - p);
    $display("txn w8 mode=%0d num=%0d root=%0d rem=%0d lat=%0d", m, n, b8.root, b8.rem, lat);
  endtask

  initial begin
    int lat, bc, total, dones;
    logic [31:0] rn;
    bit          rm;
    longint unsigned r;

    vecs[0]  = '{1'b0, 32'd4294967295, 16'd65535, 32'd131070};
    vecs[1]  = '{1'b1, 32'd4294967295, 16'd1625,  32'd3951670};
    vecs[2]  = '{1'b0, 32'd1000000,    16'd1000,  32'd0};
    vecs[3]  = '{1'b1, 32'd1000000,    16'd100,   32'd0};
    vecs[4]  = '{1'b1, 32'd26,         16'd2,     32'd18};
    vecs[5]  = '{1'b0, 32'd0,          16'd0,     32'd0};
    vecs[6]  = '{1'b1, 32'd0,          16'd0,     32'd0};
    vecs[7]  = '{1'b0, 32'd15,         16'd3,     32'd6};
    vecs[8]  = '{1'b1, 32'd7,          16'd1,     32'd6};
    vecs[9]  = '{1'b1, 32'd8,          16'd2,     32'd0};
    vecs[10] = '{1'b0, 32'd16,         16'd4,     32'd0};

    b32.start = 1'b0; b32.mode = 1'b0; b32.num = '0;
    b8.start  = 1'b0; b8.mode  = 1'b0; b8.num  = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", b32.busy, 0);
    check("reset_done", b32.done, 0);
    check("reset_root", b32.root, 0);
    check("reset_rem", b32.rem, 0);
    check("reset_busy_w8", b8.busy, 0);
    check("reset_root_w8", b8.root, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++)
      op32(vecs[i].mode, vecs[i].num, vecs[i].root, vecs[i].rem);

    // Back-to-back: new start presented during the done cycle.
    op32(1'b0, 32'd1000000, 16'd1000, 32'd0);
    launch32(1'b1, 32'd1000000);
    check("b2b_done_pulse_one_cycle", b32.done, 0);
    check("b2b_accepted_busy", b32.busy, 1);
    wait32(lat, bc);
    check("b2b_latency", lat, 11);
    check("b2b_root", b32.root, 100);
    check("b2b_rem", b32.rem, 0);
    $display("txn w32 back-to-back cube root=%0d rem=%0d lat=%0d", b32.root, b32.rem, lat);

    // Start while busy is ignored; operand changes mid-flight have no effect.
    @(negedge clk);
    launch32(1'b0, 32'd4294967295);
    repeat (4) begin @(posedge clk); #1; end
    b32.start = 1'b1; b32.mode = 1'b1; b32.num = 32'd16;
    @(posedge clk); #1;
    b32.start = 1'b0; b32.mode = 1'b0; b32.num = 32'd7;
    check("held_root_while_busy", b32.root, 100);
    check("held_rem_while_busy", b32.rem, 0);
    wait32(lat, bc);
    total = lat + 5;
    check("ignored_start_latency", total, 16);
    check("ignored_start_root", b32.root, 65535);
    check("ignored_start_rem", b32.rem, 131070);
    $display("txn w32 start-while-busy root=%0d rem=%0d lat=%0d", b32.root, b32.rem, total);

    // Reset in the middle of an operation.
    @(negedge clk);
    launch32(1'b0, 32'd4294967295);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", b32.busy, 0);
    check("midrst_done", b32.done, 0);
    check("midrst_root", b32.root, 0);
    check("midrst_rem", b32.rem, 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (b32.done || b32.busy) dones++;
    end
    check("midrst_no_done_or_busy", dones, 0);
    $display("txn w32 reset mid-operation");
    op32(1'b0, 32'd4294967295, 16'd65535, 32'd131070);

    // Random sweep at WIDTH=32 against the search model.
    for (int i = 0; i < 24; i++) begin
      rn = $urandom;
      rm = 1'($urandom_range(0, 1));
      r  = iroot(64'(rn), rm, 16);
      op32(rm, rn, 16'(r), 32'(64'(rn) - (rm ? r * r * r : r * r)));
    end

    // WIDTH=8: extremes plus random operands, both modes.
    op8(1'b0, 8'd0);
    op8(1'b1, 8'd0);
    op8(1'b0, 8'd255);
    op8(1'b1, 8'd255);
    op8(1'b1, 8'd125);
    op8(1'b0, 8'd224);
    for (int i = 0; i < 40; i++)
      op8(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/root_unit.md
Name: root_unit

Overview:
- Parametrised, sequential integer root engine for a WIDTH-bit unsigned operand.
- Computes the floor square root or floor cube root, selected per operation by a mode input, plus the remainder.
- Decides one result bit per clock (restoring trial method) under a start/busy/done handshake.
- Replaces fixed-width combinational root logic in datapaths that need to share one unit across both root kinds.

Parameters:
- WIDTH, 32, operand width in bits; legal range 4..64.
- RW, (WIDTH+1)/2, root output width (derived; square root is the widest result).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request a new operation; sampled only while idle.
- mode, input, 1, 0 = square root, 1 = cube root; sampled with start.
- num, input, WIDTH, unsigned operand; sampled with start.
- busy, output, 1, operation in progress.
- done, output, 1, single-cycle pulse: root and rem are valid.
- root, output, RW, floor(num^(1/2)) or floor(num^(1/3)).
- rem, output, WIDTH, num - root^2 or num - root^3.

Behaviour:
- Reset:
  - rst high at a clock edge forces state IDLE; busy=0, done=0, root=0, rem=0.
  - All internal registers clear.
  - Reset aborts any operation in flight; no done pulse is produced for the aborted operation.
- Iteration count N:
  - Square root: N = (WIDTH+1)/2.
  - Cube root: N = (WIDTH+2)/3.
  - For WIDTH=32: N = 16 (square), 11 (cube).
- States:
  - IDLE: done is low unless the previous edge finished an operation. On an edge with start=1, latch num and mode, clear the partial result, set the bit index to N-1, set busy=1, go to CALC.
  - CALC: each edge computes trial = partial | (1<<idx) and power = trial^2 or trial^3.
    - Power is evaluated at 3*RW bits so it never overflows.
    - If power <= latched num (zero-extended), keep the bit; otherwise drop it.
    - While idx > 0: decrement idx and stay in CALC.
    - On the edge deciding idx = 0: load root with the final result, load rem = num - final^k (truncated to WIDTH bits; it always fits), set done=1, busy=0, go to IDLE.
- done:
  - Registered; high for exactly one cycle, then low on the next edge.
  - Cube-mode root upper bits above N are always 0.
- Latency: done is asserted N edges after the edge that sampled start. busy is high for exactly N cycles.
- Held outputs: root and rem hold their last values until the next completion or reset. They do not change while busy.
- start while busy: ignored. The latched operand and mode do not change, and no queueing occurs.
- start during the done cycle: accepted (state is IDLE), so operations can run back-to-back with no gap.
- num and mode changing while busy: no effect on the operation in flight.
- num = 0: root = 0, rem = 0, full N-cycle latency (no early exit).

Test Plan:
- WIDTH=32, mode=0, num=4294967295 -> done on the 16th edge after start; root=65535, rem=131070; busy high for 16 cycles.
- WIDTH=32, mode=1, num=4294967295 -> done after 11 edges; root=1625, rem=3951670.
- mode=0 num=1000000 -> root=1000, rem=0. Then start asserted during the done cycle with mode=1 num=1000000 -> accepted, root=100, rem=0 after 11 more edges. Also cover mode=1 num=26 -> root=2, rem=18 and num=0 -> root=0, rem=0.
- Start square root of 4294967295, then pulse start with num=16 at cycle 5 -> ignored; result is still 65535 / 131070 at the original done time.
- Reset mid-operation: rst high at cycle 6 of a square-root operation -> busy=0, done=0, root=0, rem=0 on the next edge; no done pulse. A fresh start afterwards completes normally.
- Random sweep, WIDTH=32 and WIDTH=8, both modes -> root^k <= num < (root+1)^k and rem = num - root^k for every result; latency always exactly N.
